iic_target: RTL and testbench
=============================

Name: iic_target

Overview:
- I2C responder (target) for the on-board register-mapped devices. It is the far end of the team's simple I2C initiator.
- Decodes START/STOP, matches a 7-bit device address, and accepts a register pointer byte followed by write bytes, or returns read bytes with pointer auto-increment.
- Presents a single-cycle strobe register-file interface to the local design. Open-drain SDA is modelled as a pull-low enable.

Parameters:
FILTER_LEN, 3, consecutive identical synchronized samples required before an SCL/SDA level change is accepted (glitch filter, 1..7)
SYNC_STAGES, 2, flip-flop synchronizer depth on scl_in and sda_in (2..3)

Ports:
clk  input  1  system clock
reset_n  input  1  active-low reset
dev_addr  input  7  target address compared against the first byte after START
scl_in  input  1  bus SCL level (asynchronous)
sda_in  input  1  bus SDA level (asynchronous)
sda_oe  output  1  1 = pull SDA low; 0 = release
reg_addr  output  8  current register pointer
reg_wr  output  1  one-cycle write strobe
reg_wdata  output  8  write data, valid while reg_wr=1
reg_rd  output  1  one-cycle read request for reg_addr
reg_rdata  input  8  read data; must be valid on the clk after reg_rd
busy  output  1  1 from address match until STOP/START

Behaviour:
- Interface: one clock, clk. reset_n is synchronous and active-low, sampled on posedge clk.
- Reset values: sda_oe=0, reg_addr=0, reg_wr=0, reg_wdata=0, reg_rd=0, busy=0, state=IDLE. The synchronizer and filter outputs reset to 1.
- Input path:
  - SYNC_STAGES flip-flops, then the FILTER_LEN glitch filter, giving scl_f and sda_f.
  - Edge flags scl_rise and scl_fall are derived from scl_f, one clk wide.
- Bus conditions (checked in every state, override all other transitions):
  - START: sda_f falls while scl_f=1. Go to ADDR, clear the bit counter, sda_oe=0. This also covers a repeated START.
  - STOP: sda_f rises while scl_f=1. Go to IDLE, sda_oe=0, busy=0. The pointer is retained.
- Data sampling and driving:
  - Bits are sampled MSB first on scl_rise.
  - sda_oe changes only on scl_fall, so the target never changes SDA while SCL is high.
- States:
  - IDLE: ignore the bus except START.
  - ADDR: shift 8 bits. On the 8th scl_rise, compare [7:1] with dev_addr.
    - Match: latch rw=[0], set busy=1, and assert sda_oe=1 on the next scl_fall (ACK).
    - Mismatch: go to IDLE without driving SDA.
  - ADDR_ACK: ACK held for one SCL period.
    - rw=0: at the ACK scl_fall that releases SDA, go to PTR.
    - rw=1: pulse reg_rd at the ACK scl_rise, capture reg_rdata into the shift register next clk, drive bit7 at the ACK-ending scl_fall, then go to RDATA.
  - PTR: shift 8 bits, load reg_addr on the 8th scl_rise, then ACK, then go to WDATA.
  - WDATA: shift 8 bits. On the 8th scl_rise, output reg_wdata and pulse reg_wr with the current reg_addr, then ACK. Increment reg_addr (mod 256, 0xFF wraps to 0x00) one clk after reg_wr. Repeat for each byte.
  - RDATA:
    - Drive sda_oe = ~shift[7] at each scl_fall; release SDA at the 8th bit's ending scl_fall.
    - Increment reg_addr once per byte after the 8th bit.
    - At the master ACK-bit scl_rise, sample sda_f.
      - 0 (ACK): pulse reg_rd and continue with the next byte.
      - 1 (NACK): go to WAIT_STOP.
  - WAIT_STOP: SDA released; only STOP or START exit.
- Simultaneous events: STOP or START in the same clk as scl_rise or scl_fall takes priority; no strobe is issued in that clk.
- Reset mid-transfer: immediate return to reset values on the next clk edge with reset_n=0; the bus is released within one clk.
- At most one of reg_wr / reg_rd is asserted in any clk; each is exactly 1 clk wide.

Decomposition:
- Package iic_pkg: state enum typedef (IDLE, ADDR, ADDR_ACK, PTR, PTR_ACK, WDATA, WDATA_ACK, RDATA, RDATA_ACK, WAIT_STOP) and constants for the R/W bit values and ACK/NACK levels. These are shared with the initiator.
- Sub-module iic_line_filter: synchronizer, glitch filter and edge detect, instantiated twice (SCL and SDA).

Test Plan:
- Write: dev_addr=0x3C; bus START, 0x78, 0x10, 0xAB, 0xCD, STOP -> ACK on all 4 bytes; reg_wr with addr 0x10/data 0xAB, then addr 0x11/data 0xCD; reg_addr ends at 0x12.
- Read: START, 0x78, 0x20, repeated START, 0x79, read 2 bytes (ACK then NACK), STOP; reg_rdata returns 0x5A, 0xA5 -> SDA carries 0x5A, 0xA5; exactly 2 reg_rd pulses; busy=0 after STOP.
- Address mismatch: 0x7A with dev_addr=0x3C -> sda_oe stays 0 for the entire frame; no strobes.
- Wrap: pointer 0xFF, write 2 bytes -> reg_wr at 0xFF then 0x00.
- Glitch and timing: 1-clk SCL pulse during a data byte -> ignored, byte still decoded correctly; assert sda_oe never toggles while scl_f=1.
- Reset mid-read: reset_n=0 while driving a 0 bit -> sda_oe=0 next clk; after release, state is IDLE and a new write frame is accepted.

Source files
------------

// File: rtl/iic_pkg.sv
// Shared I2C definitions: target FSM states, R/W bit values and ACK/NACK bus levels.
package iic_pkg;

    typedef enum logic [3:0] {
        StIdle,
        StAddr,
        StAddrAck,
        StPtr,
        StPtrAck,
        StWdata,
        StWdataAck,
        StRdata,
        StRdataAck,
        StWaitStop
    } iic_state_e;

    localparam logic RwWrite   = 1'b0;
    localparam logic RwRead    = 1'b1;
    localparam logic AckLevel  = 1'b0;
    localparam logic NackLevel = 1'b1;

endpackage

// File: rtl/iic_line_filter.sv
// Synchronizer, glitch filter and one-clk edge flags for a single I2C line.
module iic_line_filter #(
    parameter int unsigned FILTER_LEN  = 3,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic reset_n,
    input  logic line_in,
    output logic level,
    output logic rise,
    output logic fall
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic [2:0]             cnt_q;
    logic                   level_q;
    logic                   rise_q;
    logic                   fall_q;
    logic                   sync_out;

    assign sync_out = sync_q[SYNC_STAGES-1];

    // A new level is accepted only after FILTER_LEN consecutive differing samples;
    // the edge flags are raised in the same clk the filtered level changes.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            sync_q  <= '1;
            cnt_q   <= '0;
            level_q <= 1'b1;
            rise_q  <= 1'b0;
            fall_q  <= 1'b0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], line_in};
            rise_q <= 1'b0;
            fall_q <= 1'b0;
            if (sync_out == level_q) begin
                cnt_q <= '0;
            end else if (cnt_q == 3'(FILTER_LEN - 1)) begin
                level_q <= sync_out;
                rise_q  <= sync_out;
                fall_q  <= ~sync_out;
                cnt_q   <= '0;
            end else begin
                cnt_q <= cnt_q + 3'd1;
            end
        end
    end

    assign level = level_q;
    assign rise  = rise_q;
    assign fall  = fall_q;

endmodule

// File: rtl/iic_target.sv
// I2C target: address match, register pointer, write strobes and auto-incrementing reads.
module iic_target
    import iic_pkg::*;
#(
    parameter int unsigned FILTER_LEN  = 3,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic [6:0] dev_addr,
    input  logic       scl_in,
    input  logic       sda_in,
    output logic       sda_oe,
    output logic [7:0] reg_addr,
    output logic       reg_wr,
    output logic [7:0] reg_wdata,
    output logic       reg_rd,
    input  logic [7:0] reg_rdata,
    output logic       busy
);

    logic scl_f, scl_rise, scl_fall;
    logic sda_f, sda_rise, sda_fall;

    iic_line_filter #(.FILTER_LEN(FILTER_LEN), .SYNC_STAGES(SYNC_STAGES)) u_scl_filter (
        .clk     (clk),
        .reset_n (reset_n),
        .line_in (scl_in),
        .level   (scl_f),
        .rise    (scl_rise),
        .fall    (scl_fall)
    );

    iic_line_filter #(.FILTER_LEN(FILTER_LEN), .SYNC_STAGES(SYNC_STAGES)) u_sda_filter (
        .clk     (clk),
        .reset_n (reset_n),
        .line_in (sda_in),
        .level   (sda_f),
        .rise    (sda_rise),
        .fall    (sda_fall)
    );

    iic_state_e state_q, state_d;
    logic [7:0] shift_q, shift_d;
    logic [2:0] bit_cnt_q, bit_cnt_d;
    logic [7:0] addr_q, addr_d;
    logic [7:0] wdata_q, wdata_d;
    logic       rw_q, rw_d;
    logic       oe_q, oe_d;
    logic       busy_q, busy_d;
    logic       wr_q, wr_d;
    logic       rd_q, rd_d;
    logic       cap_q, cap_d;
    logic       inc_q, inc_d;
    logic [7:0] shift_in;
    logic       start_cond, stop_cond;

    assign shift_in   = {shift_q[6:0], sda_f};
    assign start_cond = sda_fall & scl_f;
    assign stop_cond  = sda_rise & scl_f;

    always_comb begin
        state_d   = state_q;
        shift_d   = shift_q;
        bit_cnt_d = bit_cnt_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        rw_d      = rw_q;
        oe_d      = oe_q;
        busy_d    = busy_q;
        wr_d      = 1'b0;
        rd_d      = 1'b0;
        cap_d     = 1'b0;
        inc_d     = 1'b0;

        if (cap_q) shift_d = reg_rdata;
        if (inc_q) addr_d = addr_q + 8'd1;

        if (start_cond) begin
            state_d   = StAddr;
            bit_cnt_d = '0;
            oe_d      = 1'b0;
            busy_d    = 1'b0;
        end else if (stop_cond) begin
            state_d = StIdle;
            oe_d    = 1'b0;
            busy_d  = 1'b0;
        end else begin
            unique case (state_q)
                StIdle: ;
                StAddr: begin
                    if (scl_rise) begin
                        shift_d   = shift_in;
                        bit_cnt_d = bit_cnt_q + 3'd1;
                        if (bit_cnt_q == 3'd7) begin
                            if (shift_in[7:1] == dev_addr) begin
                                rw_d    = shift_in[0];
                                busy_d  = 1'b1;
                                state_d = StAddrAck;
                            end else begin
                                state_d = StIdle;
                            end
                        end
                    end
                end
                // First scl_fall starts the ACK, the second one ends it.
                StAddrAck: begin
                    if (scl_rise && rw_q == RwRead) begin
                        rd_d  = 1'b1;
                        cap_d = 1'b1;
                    end
                    if (scl_fall) begin
                        if (!oe_q) begin
                            oe_d = 1'b1;
                        end else if (rw_q == RwRead) begin
                            oe_d      = ~shift_q[7];
                            bit_cnt_d = '0;
                            state_d   = StRdata;
                        end else begin
                            oe_d    = 1'b0;
                            state_d = StPtr;
                        end
                    end
                end
                StPtr: begin
                    if (scl_rise) begin
                        shift_d   = shift_in;
                        bit_cnt_d = bit_cnt_q + 3'd1;
                        if (bit_cnt_q == 3'd7) begin
                            addr_d  = shift_in;
                            state_d = StPtrAck;
                        end
                    end
                end
                StPtrAck, StWdataAck: begin
                    if (scl_fall) begin
                        if (!oe_q) begin
                            oe_d = 1'b1;
                        end else begin
                            oe_d    = 1'b0;
                            state_d = StWdata;
                        end
                    end
                end
                StWdata: begin
                    if (scl_rise) begin
                        shift_d   = shift_in;
                        bit_cnt_d = bit_cnt_q + 3'd1;
                        if (bit_cnt_q == 3'd7) begin
                            wdata_d = shift_in;
                            wr_d    = 1'b1;
                            inc_d   = 1'b1;
                            state_d = StWdataAck;
                        end
                    end
                end
                StRdata: begin
                    if (scl_rise) begin
                        bit_cnt_d = bit_cnt_q + 3'd1;
                        if (bit_cnt_q == 3'd7) begin
                            addr_d  = addr_q + 8'd1;
                            state_d = StRdataAck;
                        end
                    end
                    if (scl_fall) begin
                        shift_d = {shift_q[6:0], 1'b0};
                        oe_d    = ~shift_q[6];
                    end
                end
                // bit_cnt 0: before the master ACK bit, 1: master has ACKed.
                StRdataAck: begin
                    if (scl_rise) begin
                        if (sda_f == AckLevel) begin
                            rd_d      = 1'b1;
                            cap_d     = 1'b1;
                            bit_cnt_d = 3'd1;
                        end else begin
                            state_d = StWaitStop;
                        end
                    end
                    if (scl_fall) begin
                        if (bit_cnt_q == 3'd0) begin
                            oe_d = 1'b0;
                        end else begin
                            oe_d      = ~shift_q[7];
                            bit_cnt_d = '0;
                            state_d   = StRdata;
                        end
                    end
                end
                StWaitStop: ;
                default: state_d = StIdle;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q   <= StIdle;
            shift_q   <= '0;
            bit_cnt_q <= '0;
            addr_q    <= '0;
            wdata_q   <= '0;
            rw_q      <= RwWrite;
            oe_q      <= 1'b0;
            busy_q    <= 1'b0;
            wr_q      <= 1'b0;
            rd_q      <= 1'b0;
            cap_q     <= 1'b0;
            inc_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            shift_q   <= shift_d;
            bit_cnt_q <= bit_cnt_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            rw_q      <= rw_d;
            oe_q      <= oe_d;
            busy_q    <= busy_d;
            wr_q      <= wr_d;
            rd_q      <= rd_d;
            cap_q     <= cap_d;
            inc_q     <= inc_d;
        end
    end

    assign sda_oe    = oe_q;
    assign reg_addr  = addr_q;
    assign reg_wr    = wr_q;
    assign reg_wdata = wdata_q;
    assign reg_rd    = rd_q;
    assign busy      = busy_q;

endmodule

// File: tb/tb_iic_target.sv
// Bench for iic_target: bit-level I2C master, register-file responder and transaction model.
module tb_iic_target;

    localparam int H = 16;  // clks per SCL half period
    localparam int Q = 8;   // clks after SCL falls before the master changes SDA

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic [6:0] dev_addr = 7'h3C;
    logic       scl_m = 1'b1;
    logic       sda_m = 1'b1;
    logic       scl_in, sda_in, sda_oe, reg_wr, reg_rd, busy;
    logic [7:0] reg_addr, reg_wdata, reg_rdata;

    logic [7:0] mem [256];
    logic [7:0] ref_mem [256];
    logic [7:0] wr_addr_q[$], wr_data_q[$], rd_addr_q[$], tx_q[$], got_q[$];
    int n_checks = 0, n_fail = 0;
    int oe_high_cnt = 0, oe_viol_cnt = 0, strobe_viol_cnt = 0;
    logic prev_oe = 1'b0, prev_wr = 1'b0, prev_rd = 1'b0;

    always #5 clk = ~clk;

    assign scl_in    = scl_m;
    assign sda_in    = sda_m & ~sda_oe;
    assign reg_rdata = mem[reg_addr];

    iic_target #(.FILTER_LEN(3), .SYNC_STAGES(2)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .dev_addr  (dev_addr),
        .scl_in    (scl_in),
        .sda_in    (sda_in),
        .sda_oe    (sda_oe),
        .reg_addr  (reg_addr),
        .reg_wr    (reg_wr),
        .reg_wdata (reg_wdata),
        .reg_rd    (reg_rd),
        .reg_rdata (reg_rdata),
        .busy      (busy)
    );

    // Register-file responder plus bus/strobe monitors.
    always @(negedge clk) begin
        if (reset_n) begin
            if (reg_wr) begin
                wr_addr_q.push_back(reg_addr);
                wr_data_q.push_back(reg_wdata);
                mem[reg_addr] = reg_wdata;
            end
            if (reg_rd) rd_addr_q.push_back(reg_addr);
            if (sda_oe) oe_high_cnt++;
            if (sda_oe !== prev_oe && scl_m) oe_viol_cnt++;
            if ((reg_wr && reg_rd) || (reg_wr && prev_wr) || (reg_rd && prev_rd))
                strobe_viol_cnt++;
        end
        prev_oe = sda_oe;
        prev_wr = reg_wr;
        prev_rd = reg_rd;
    end

    initial begin
        #900us;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic wait_clks(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic clock_bit(input logic b, input bit glitch, output logic r);
        wait_clks(Q);
        sda_m = b;
        if (glitch) begin
            wait_clks(4);
            scl_m = 1'b1;
            wait_clks(1);
            scl_m = 1'b0;
            wait_clks(H - Q - 5);
        end else begin
            wait_clks(H - Q);
        end
        scl_m = 1'b1;
        wait_clks(H);
        r = sda_in;
        scl_m = 1'b0;
    endtask

    task automatic bus_start();
        if (!scl_m) begin
            wait_clks(Q);
            sda_m = 1'b1;
            wait_clks(H - Q);
            scl_m = 1'b1;
            wait_clks(H);
        end
        sda_m = 1'b0;
        wait_clks(H);
        scl_m = 1'b0;
    endtask

    task automatic bus_stop();
        wait_clks(Q);
        sda_m = 1'b0;
        wait_clks(H - Q);
        scl_m = 1'b1;
        wait_clks(H);
        sda_m = 1'b1;
        wait_clks(H);
    endtask

    task automatic send_byte(input logic [7:0] b, input int glitch_bit, output logic ack);
        logic r;
        for (int i = 7; i >= 0; i--) clock_bit(b[i], (i == glitch_bit), r);
        clock_bit(1'b1, 1'b0, ack);
    endtask

    task automatic recv_byte(input logic m_ack, output logic [7:0] b);
        logic r;
        b = '0;
        for (int i = 0; i < 8; i++) begin
            clock_bit(1'b1, 1'b0, r);
            b = {b[6:0], r};
        end
        clock_bit(m_ack, 1'b0, r);
    endtask

    task automatic clear_logs();
        wr_addr_q.delete();
        wr_data_q.delete();
        rd_addr_q.delete();
        got_q.delete();
    endtask

    // Writes tx_q starting at ptr; nacks counts bytes the target failed to ACK.
    task automatic run_write(input logic [7:0] ptr, input int glitch_bit, output int nacks);
        logic a;
        nacks = 0;
        bus_start();
        send_byte({dev_addr, 1'b0}, -1, a);
        nacks += int'(a);
        send_byte(ptr, -1, a);
        nacks += int'(a);
        foreach (tx_q[i]) begin
            send_byte(tx_q[i], (i == 0) ? glitch_bit : -1, a);
            nacks += int'(a);
        end
        bus_stop();
    endtask

    // Reads n bytes from ptr into got_q, NACKing the last one.
    task automatic run_read(input logic [7:0] ptr, input int n, output int nacks);
        logic a;
        logic [7:0] b;
        nacks = 0;
        bus_start();
        send_byte({dev_addr, 1'b0}, -1, a);
        nacks += int'(a);
        send_byte(ptr, -1, a);
        nacks += int'(a);
        bus_start();
        send_byte({dev_addr, 1'b1}, -1, a);
        nacks += int'(a);
        for (int i = 0; i < n; i++) begin
            recv_byte((i == n - 1) ? 1'b1 : 1'b0, b);
            got_q.push_back(b);
        end
        bus_stop();
    endtask

    // Compares logged writes against the model and applies them to ref_mem.
    task automatic check_writes(input string tag, input logic [7:0] ptr);
        n_checks++;
        if (wr_addr_q.size() !== tx_q.size()) begin
            n_fail++;
            $display("FAIL %s_wr_count: got %0d expected %0d", tag, wr_addr_q.size(), tx_q.size());
        end else begin
            foreach (tx_q[i]) begin
                logic [7:0] ea;
                ea = 8'(int'(ptr) + i);
                ref_mem[ea] = tx_q[i];
                n_checks++;
                if (wr_addr_q[i] !== ea || wr_data_q[i] !== tx_q[i]) begin
                    n_fail++;
                    $display("FAIL %s_wr[%0d]: got %02h/%02h expected %02h/%02h", tag, i,
                             wr_addr_q[i], wr_data_q[i], ea, tx_q[i]);
                end
            end
        end
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        wait_clks(5);
        n_checks++;
        if ({sda_oe, reg_wr, reg_rd, busy} !== 4'b0) begin
            n_fail++;
            $display("FAIL reset_ctrl: got %b expected 0000", {sda_oe, reg_wr, reg_rd, busy});
        end
        n_checks++;
        if (reg_addr !== 8'h00 || reg_wdata !== 8'h00) begin
            n_fail++;
            $display("FAIL reset_regs: got %02h/%02h expected 00/00", reg_addr, reg_wdata);
        end
        reset_n = 1'b1;
        wait_clks(H);
    endtask

    task automatic test_write();
        logic a;
        int nacks = 0;
        clear_logs();
        tx_q = '{8'hAB, 8'hCD};
        bus_start();
        send_byte(8'h78, -1, a);
        nacks += int'(a);
        n_checks++;
        if (busy !== 1'b1) begin
            n_fail++;
            $display("FAIL write_busy: got %b expected 1", busy);
        end
        send_byte(8'h10, -1, a);
        nacks += int'(a);
        foreach (tx_q[i]) begin
            send_byte(tx_q[i], -1, a);
            nacks += int'(a);
        end
        bus_stop();
        n_checks++;
        if (nacks !== 0) begin
            n_fail++;
            $display("FAIL write_acks: got %0d nacks expected 0", nacks);
        end
        check_writes("write", 8'h10);
        n_checks++;
        if (reg_addr !== 8'h12 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL write_end: got addr %02h busy %b expected 12/0", reg_addr, busy);
        end
    endtask

    task automatic test_read();
        int nacks;
        clear_logs();
        mem[8'h20] = 8'h5A;
        mem[8'h21] = 8'hA5;
        ref_mem[8'h20] = 8'h5A;
        ref_mem[8'h21] = 8'hA5;
        run_read(8'h20, 2, nacks);
        n_checks++;
        if (nacks !== 0) begin
            n_fail++;
            $display("FAIL read_acks: got %0d nacks expected 0", nacks);
        end
        n_checks++;
        if (got_q.size() !== 2 || got_q[0] !== 8'h5A || got_q[1] !== 8'hA5) begin
            n_fail++;
            $display("FAIL read_data: got %p expected 5a,a5", got_q);
        end
        n_checks++;
        if (rd_addr_q.size() !== 2 || rd_addr_q[0] !== 8'h20 || rd_addr_q[1] !== 8'h21) begin
            n_fail++;
            $display("FAIL read_strobes: got %p expected 20,21", rd_addr_q);
        end
        n_checks++;
        if (busy !== 1'b0 || reg_addr !== 8'h22) begin
            n_fail++;
            $display("FAIL read_end: got busy %b addr %02h expected 0/22", busy, reg_addr);
        end
    endtask

    task automatic test_mismatch();
        logic a, a2;
        clear_logs();
        oe_high_cnt = 0;
        bus_start();
        send_byte(8'h7A, -1, a);
        send_byte(8'h55, -1, a2);
        bus_stop();
        n_checks++;
        if (a !== 1'b1 || oe_high_cnt !== 0) begin
            n_fail++;
            $display("FAIL mismatch_oe: got ack %b oe clks %0d expected 1/0", a, oe_high_cnt);
        end
        n_checks++;
        if (wr_addr_q.size() + rd_addr_q.size() !== 0 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL mismatch_strobes: got %0d strobes busy %b expected 0/0",
                     wr_addr_q.size() + rd_addr_q.size(), busy);
        end
    endtask

    task automatic test_wrap();
        int nacks;
        clear_logs();
        tx_q = '{8'($urandom), 8'($urandom)};
        run_write(8'hFF, -1, nacks);
        n_checks++;
        if (nacks !== 0) begin
            n_fail++;
            $display("FAIL wrap_acks: got %0d nacks expected 0", nacks);
        end
        check_writes("wrap", 8'hFF);
        n_checks++;
        if (reg_addr !== 8'h01) begin
            n_fail++;
            $display("FAIL wrap_ptr: got %02h expected 01", reg_addr);
        end
    endtask

    task automatic test_glitch();
        int nacks;
        logic [7:0] ptr;
        clear_logs();
        ptr = 8'($urandom);
        tx_q = '{8'($urandom)};
        run_write(ptr, 4, nacks);
        n_checks++;
        if (nacks !== 0) begin
            n_fail++;
            $display("FAIL glitch_acks: got %0d nacks expected 0", nacks);
        end
        check_writes("glitch", ptr);
        n_checks++;
        if (oe_viol_cnt !== 0) begin
            n_fail++;
            $display("FAIL oe_while_scl_high: got %0d changes expected 0", oe_viol_cnt);
        end
    endtask

    task automatic test_random();
        int nacks, n;
        logic [7:0] ptr;
        for (int it = 0; it < 4; it++) begin
            clear_logs();
            ptr = 8'($urandom);
            n = $urandom_range(1, 3);
            tx_q.delete();
            for (int i = 0; i < n; i++) tx_q.push_back(8'($urandom));
            run_write(ptr, -1, nacks);
            check_writes("rand_write", ptr);
            clear_logs();
            run_read(ptr, n + 1, nacks);
            n_checks++;
            if (nacks !== 0) begin
                n_fail++;
                $display("FAIL rand_acks[%0d]: got %0d nacks expected 0", it, nacks);
            end
            for (int i = 0; i <= n; i++) begin
                logic [7:0] ea;
                ea = 8'(int'(ptr) + i);
                n_checks++;
                if (got_q[i] !== ref_mem[ea] || rd_addr_q[i] !== ea) begin
                    n_fail++;
                    $display("FAIL rand_read[%0d.%0d]: got %02h@%02h expected %02h@%02h", it, i,
                             got_q[i], rd_addr_q[i], ref_mem[ea], ea);
                end
            end
        end
    endtask

    task automatic test_reset_mid_read();
        logic a;
        int nacks, k;
        clear_logs();
        mem[8'h40] = 8'h00;
        ref_mem[8'h40] = 8'h00;
        bus_start();
        send_byte({dev_addr, 1'b0}, -1, a);
        send_byte(8'h40, -1, a);
        bus_start();
        send_byte({dev_addr, 1'b1}, -1, a);
        k = 0;
        while (!sda_oe && k < 4 * H) begin
            wait_clks(1);
            k++;
        end
        n_checks++;
        if (sda_oe !== 1'b1) begin
            n_fail++;
            $display("FAIL mid_read_drive: got sda_oe %b expected 1 within %0d clks", sda_oe, 4 * H);
        end
        reset_n = 1'b0;
        wait_clks(1);
        n_checks++;
        if (sda_oe !== 1'b0 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL mid_read_reset: got oe %b busy %b expected 0/0", sda_oe, busy);
        end
        wait_clks(2);
        reset_n = 1'b1;
        sda_m = 1'b1;
        scl_m = 1'b1;
        wait_clks(H);
        n_checks++;
        if (reg_addr !== 8'h00) begin
            n_fail++;
            $display("FAIL mid_read_ptr: got %02h expected 00", reg_addr);
        end
        clear_logs();
        tx_q = '{8'($urandom)};
        run_write(8'h33, -1, nacks);
        n_checks++;
        if (nacks !== 0) begin
            n_fail++;
            $display("FAIL after_reset_acks: got %0d nacks expected 0", nacks);
        end
        check_writes("after_reset", 8'h33);
    endtask

    task automatic test_strobes();
        n_checks++;
        if (strobe_viol_cnt !== 0) begin
            n_fail++;
            $display("FAIL strobe_shape: got %0d violations expected 0", strobe_viol_cnt);
        end
    endtask

    initial begin
        for (int i = 0; i < 256; i++) begin
            mem[i] = 8'($urandom);
            ref_mem[i] = mem[i];
        end
        test_reset();
        test_write();
        test_read();
        test_mismatch();
        test_wrap();
        test_glitch();
        test_random();
        test_reset_mid_read();
        test_strobes();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
